// File: rtl/quad_pkg.sv
// Shared types, constants and phase-sequence helpers for the quadrature decoder.
// Optional glitch filter is enabled by defining QUAD_GLITCH_FILTER_EN.
package quad_pkg;

  // Gray-coded {A,B} phase states; encodings equal the raw channel bits.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Next phase when moving up: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t phase_next_up(input phase_t ph);
    phase_t nx;
    case (ph)
      PH_00:   nx = PH_01;
      PH_01:   nx = PH_11;
      PH_11:   nx = PH_10;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

  // Next phase when moving down: reverse of the up sequence.
  function automatic phase_t phase_next_dn(input phase_t ph);
    phase_t nx;
    case (ph)
      PH_00:   nx = PH_10;
      PH_10:   nx = PH_11;
      PH_11:   nx = PH_01;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer for one quadrature channel, followed by an optional
// consecutive-cycle glitch filter (QUAD_GLITCH_FILTER_EN).
// q_vld marks the first cycle from which q reflects the real input.
module quad_sync_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic q_vld
);

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;

  // Metastability synchronizer plus a fill tracker so stale reset zeros are never decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= d_in;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN

  localparam int unsigned CNT_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

  typedef enum logic {
    FS_IDLE,
    FS_RUN
  } filt_state_t;

  filt_state_t      st_q, st_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= FS_IDLE;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Load the first synchronized sample, then accept changes only after FILT stable cycles.
  always_comb begin
    st_d   = st_q;
    filt_d = filt_q;
    cnt_d  = cnt_q;
    case (st_q)
      FS_IDLE: begin
        if (fill[1]) begin
          filt_d = sync2;
          cnt_d  = '0;
          st_d   = FS_RUN;
        end
      end
      default: begin
        if (sync2 != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync2;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase
  end

  assign q     = filt_q;
  assign q_vld = (st_q == FS_RUN);

`else

  assign q     = sync2;
  assign q_vld = fill[1];

`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes (and optionally filters) A/B, decodes phase
// transitions into step/dir pulses, keeps a wrapping position count and a sticky
// illegal-transition flag. Glitch filter compiled in with QUAD_GLITCH_FILTER_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned FILT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         en_dec,
  input  logic         clr,
  input  logic         err_clr,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic [N-1:0] pos,
  output logic         max_tick,
  output logic         min_tick
);

  logic a_f, a_vld;
  logic b_f, b_vld;

  quad_sync_filter #(.FILT(FILT)) u_sync_a (
    .clk   (clk),
    .rst   (rst),
    .d_in  (a_in),
    .q     (a_f),
    .q_vld (a_vld)
  );

  quad_sync_filter #(.FILT(FILT)) u_sync_b (
    .clk   (clk),
    .rst   (rst),
    .d_in  (b_in),
    .q     (b_f),
    .q_vld (b_vld)
  );

  phase_t       cur;
  logic         ph_vld;
  phase_t       phase_q, phase_d;
  logic         init_q, init_d;
  logic         step_d, dir_d, err_d;
  logic [N-1:0] pos_d;
  logic         mv_up, mv_dn;

  assign cur    = phase_t'({a_f, b_f});
  assign ph_vld = a_vld & b_vld;

  // Decoder state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_00;
      init_q  <= 1'b0;
      step    <= 1'b0;
      dir     <= DIR_DN;
      err     <= 1'b0;
      pos     <= '0;
    end else begin
      phase_q <= phase_d;
      init_q  <= init_d;
      step    <= step_d;
      dir     <= dir_d;
      err     <= err_d;
      pos     <= pos_d;
    end
  end

  // Classify the sampled phase change and compute next step/dir/err/pos.
  always_comb begin
    phase_d = phase_q;
    init_d  = init_q;
    step_d  = 1'b0;
    dir_d   = dir;
    err_d   = err;
    pos_d   = pos;
    mv_up   = 1'b0;
    mv_dn   = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    if (ph_vld) begin
      if (!init_q) begin
        phase_d = cur;
        init_d  = 1'b1;
      end else if (cur != phase_q) begin
        phase_d = cur;
        if (cur == phase_next_up(phase_q)) begin
          mv_up = 1'b1;
        end else if (cur == phase_next_dn(phase_q)) begin
          mv_dn = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (en_dec && (mv_up || mv_dn)) begin
      step_d = 1'b1;
      dir_d  = mv_up ? DIR_UP : DIR_DN;
    end

    if (clr) begin
      pos_d = '0;
    end else if (step_d) begin
      pos_d = (dir_d == DIR_UP) ? pos + N'(1) : pos - N'(1);
    end
  end

  assign max_tick = &pos;
  assign min_tick = ~|pos;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (N=4, FILT=3).
module tb_quad_decoder;

  localparam int unsigned N    = 4;
  localparam int unsigned FILT = 3;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int unsigned LAT = 3 + FILT;
`else
  localparam int unsigned LAT = 3;
`endif

  logic         clk;
  logic         rst;
  logic         a_in;
  logic         b_in;
  logic         en_dec;
  logic         clr;
  logic         err_clr;
  logic         step;
  logic         dir;
  logic         err;
  logic [N-1:0] pos;
  logic         max_tick;
  logic         min_tick;

  int n_chk;
  int n_fail;
  int step_cnt;

  quad_decoder #(.N(N), .FILT(FILT)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .en_dec   (en_dec),
    .clr      (clr),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .pos      (pos),
    .max_tick (max_tick),
    .min_tick (min_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later and tally step pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) step_cnt++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic move(input logic a, input logic b, input int n);
    a_in = a;
    b_in = b;
    hold(n);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; step_cnt = 0;
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
    en_dec = 1'b1; clr = 1'b0; err_clr = 1'b0;

    // Reset values with a=b=1 applied.
    hold(3);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_max", 32'(max_tick), 32'd0);
    chk("rst_min", 32'(min_tick), 32'd1);

    // First sample after reset loads phase 11 silently.
    rst = 1'b0;
    step_cnt = 0;
    hold(12);
    chk("init_steps", 32'(step_cnt), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_pos", 32'(pos), 32'd0);

    // Re-reset with phase 00.
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0;
    hold(2);
    rst = 1'b0;
    hold(12);
    step_cnt = 0;

    // First forward step: pulse exactly LAT edges after the input change.
    a_in = 1'b0; b_in = 1'b1;
    for (int i = 1; i <= int'(LAT); i++) begin
      tick();
      chk("lat_step", 32'(step), (i == int'(LAT)) ? 32'd1 : 32'd0);
    end
    hold(10 - int'(LAT));
    move(1'b1, 1'b1, 10);
    move(1'b1, 1'b0, 10);
    move(1'b0, 1'b0, 10);
    move(1'b0, 1'b1, 10);
    move(1'b1, 1'b1, 10);
    move(1'b1, 1'b0, 10);
    move(1'b0, 1'b0, 10);
    chk("fwd_steps", 32'(step_cnt), 32'd8);
    chk("fwd_dir", 32'(dir), 32'd1);
    chk("fwd_pos", 32'(pos), 32'd8);

    // Clear, then wrap down and back up.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_pos", 32'(pos), 32'd0);
    chk("clr_min", 32'(min_tick), 32'd1);
    step_cnt = 0;
    move(1'b1, 1'b0, 10);
    chk("wrap_dn_pos", 32'(pos), 32'd15);
    chk("wrap_dn_max", 32'(max_tick), 32'd1);
    chk("wrap_dn_dir", 32'(dir), 32'd0);
    chk("wrap_dn_steps", 32'(step_cnt), 32'd1);
    move(1'b0, 1'b0, 10);
    chk("wrap_up_pos", 32'(pos), 32'd0);
    chk("wrap_up_min", 32'(min_tick), 32'd1);
    chk("wrap_up_dir", 32'(dir), 32'd1);

    // Illegal jump 00 -> 11.
    step_cnt = 0;
    move(1'b1, 1'b1, 10);
    chk("jump_err", 32'(err), 32'd1);
    chk("jump_pos", 32'(pos), 32'd0);
    chk("jump_steps", 32'(step_cnt), 32'd0);
    chk("jump_dir", 32'(dir), 32'd1);

    // Phase tracked 11; move down to 01, then clear err.
    move(1'b0, 1'b1, 10);
    chk("dn_after_jump_pos", 32'(pos), 32'd15);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr", 32'(err), 32'd0);

    // Jump 01 -> 10 with err_clr held through the detecting edge.
    err_clr = 1'b1;
    a_in = 1'b1; b_in = 1'b0;
    hold(int'(LAT));
    err_clr = 1'b0;
    hold(5);
    chk("err_prio", 32'(err), 32'd1);
    chk("err_prio_pos", 32'(pos), 32'd15);

    // Down step 10 -> 11 with clr in the step cycle.
    a_in = 1'b1; b_in = 1'b1;
    hold(int'(LAT) - 1);
    clr = 1'b1;
    step_cnt = 0;
    tick();
    clr = 1'b0;
    chk("clr_step", 32'(step), 32'd1);
    chk("clr_step_pos", 32'(pos), 32'd0);
    chk("clr_step_dir", 32'(dir), 32'd0);
    hold(5);
    chk("clr_step_cnt", 32'(step_cnt), 32'd1);
    chk("clr_step_pos2", 32'(pos), 32'd0);

    // Decode disabled: four forward steps produce nothing.
    en_dec = 1'b0;
    step_cnt = 0;
    move(1'b1, 1'b0, 10);
    move(1'b0, 1'b0, 10);
    move(1'b0, 1'b1, 10);
    move(1'b1, 1'b1, 10);
    chk("dis_steps", 32'(step_cnt), 32'd0);
    chk("dis_pos", 32'(pos), 32'd0);
    chk("dis_dir", 32'(dir), 32'd0);

    // Re-enabled: phase kept tracking, so 11 -> 10 counts up.
    en_dec = 1'b1;
    move(1'b1, 1'b0, 10);
    chk("reen_steps", 32'(step_cnt), 32'd1);
    chk("reen_pos", 32'(pos), 32'd1);
    chk("reen_dir", 32'(dir), 32'd1);

`ifdef QUAD_GLITCH_FILTER_EN
    // Two-cycle glitch on A is rejected.
    a_in = 1'b0;
    hold(2);
    a_in = 1'b1;
    step_cnt = 0;
    hold(12);
    chk("glitch_steps", 32'(step_cnt), 32'd0);
    chk("glitch_pos", 32'(pos), 32'd1);

    // Stable change 10 -> 00 steps exactly 6 edges later.
    a_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("filt_lat_step", 32'(step), (i == 6) ? 32'd1 : 32'd0);
    end
    hold(5);
    chk("filt_pos", 32'(pos), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
